vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 17 +
 rtl/vga_sync_gen_if.sv | 14 +
 rtl/vga_axis_counter.sv | 57 +++++
 rtl/vga_sync_gen.sv | 53 +++++
 tb/tb_vga_sync_gen.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 timing, phase type and sync-level helper
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} vga_phase_t;
  function automatic logic sync_level(input logic in_sync, input logic pol);
    return in_sync ? pol : ~pol;
  endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: run enable in, pixel timing outputs out
interface vga_sync_gen_if;
  logic       i_en;
  logic       o_pix_en;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_active;
  logic       o_line_end;
  logic       o_frame_end;
  logic [9:0] o_x;
  logic [9:0] o_y;
  modport master(output i_en, input o_pix_en, o_hsync, o_vsync, o_active, o_line_end, o_frame_end, o_x, o_y);
  modport slave(input i_en, output o_pix_en, o_hsync, o_vsync, o_active, o_line_end, o_frame_end, o_x, o_y);
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis -- position counter, phase FSM and sync level
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACT      = 640,
  parameter int FP       = 16,
  parameter int SYNC     = 96,
  parameter int BP       = 48,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_step,
  output logic       o_wrap,
  output logic [9:0] o_cnt,
  output vga_phase_t o_phase,
  output logic       o_sync
);
  localparam int          TOTAL   = ACT + FP + SYNC + BP;
  localparam logic [10:0] TOTAL_W = 11'(TOTAL);
  localparam logic [9:0]  E_ACT   = 10'(ACT - 1);
  localparam logic [9:0]  E_FP    = 10'(ACT + FP - 1);
  localparam logic [9:0]  E_SYNC  = 10'(ACT + FP + SYNC - 1);
  localparam logic [9:0]  E_TOT   = 10'(TOTAL_W - 11'd1);
  if (TOTAL > 1024) begin : g_bad_total
    $error("vga_axis_counter: total %0d exceeds 1024", TOTAL);
  end
  logic [9:0] r_cnt;
  vga_phase_t r_phase;
  logic       r_sync;
  assign o_wrap  = i_step & (r_cnt == E_TOT);
  assign o_cnt   = r_cnt;
  assign o_phase = r_phase;
  assign o_sync  = r_sync;
  // advance position and phase together so the sync level always matches the count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= PH_ACT;
      r_sync  <= sync_level(1'b0, SYNC_POL);
    end else if (i_step) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 10'd1;
      case (r_phase)
        PH_ACT:  if (r_cnt == E_ACT) r_phase <= PH_FP;
        PH_FP:   if (r_cnt == E_FP) begin
          r_phase <= PH_SYNC;
          r_sync  <= sync_level(1'b1, SYNC_POL);
        end
        PH_SYNC: if (r_cnt == E_SYNC) begin
          r_phase <= PH_BP;
          r_sync  <= sync_level(1'b0, SYNC_POL);
        end
        default: if (o_wrap) r_phase <= PH_ACT;
      endcase
    end
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel prescaler driving horizontal and vertical timing axes
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input logic           clk,
  input logic           rst,
  vga_sync_gen_if.slave bus
);
  localparam int             DW       = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be at least 1");
  end
  logic [DW-1:0] r_div;
  logic          w_pix_en;
  logic          w_h_wrap;
  logic          w_v_wrap;
  vga_phase_t    w_h_phase;
  vga_phase_t    w_v_phase;
  assign w_pix_en        = bus.i_en & (r_div == DIV_LAST);
  assign bus.o_pix_en    = w_pix_en;
  assign bus.o_line_end  = w_h_wrap;
  assign bus.o_frame_end = w_v_wrap;
  assign bus.o_active    = (w_h_phase == PH_ACT) & (w_v_phase == PH_ACT);
  // prescaler: one pixel every CLK_DIV clocks, frozen while disabled
  always_ff @(posedge clk) begin
    if (rst) r_div <= '0;
    else if (bus.i_en) r_div <= w_pix_en ? '0 : r_div + 1'b1;
  end
  vga_axis_counter #(
    .ACT(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h (
    .clk(clk), .rst(rst), .i_step(w_pix_en), .o_wrap(w_h_wrap),
    .o_cnt(bus.o_x), .o_phase(w_h_phase), .o_sync(bus.o_hsync)
  );
  vga_axis_counter #(
    .ACT(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v (
    .clk(clk), .rst(rst), .i_step(w_h_wrap), .o_wrap(w_v_wrap),
    .o_cnt(bus.o_y), .o_phase(w_v_phase), .o_sync(bus.o_vsync)
  );
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for default and small-geometry timing generators
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  vga_sync_gen_if ia();
  vga_sync_gen_if ib();

  vga_sync_gen u_a (.clk(clk), .rst(rst_a), .bus(ia));
  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (.clk(clk), .rst(rst_b), .bus(ib));

  typedef struct {string name; int exp;} chk_t;
  chk_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  int a_nfall = 0, a_hfall = 0, a_hrise = 0, a_hper = -1, a_hlow = -1, a_hfall_x = -1, a_act_delay = -1;
  logic a_hs_p = 1'bx, a_act_p = 1'bx;
  int b_nfe = 0, b_fe_t = 0, b_fper = -1, b_fe_ok = -1;
  int b_hfall = 0, b_hper = -1, b_hlow = -1, b_hfall_x = -1;
  int b_vfall = 0, b_vlow = -1, b_vfall_y = -1;
  logic b_hs_p = 1'bx, b_vs_p = 1'bx, b_fe_p = 1'b0;
  logic [19:0] b_wrap_xy = '1;

  function automatic logic [31:0] actual(input string n);
    case (n)
      "ax":          return 32'(ia.o_x);
      "ay":          return 32'(ia.o_y);
      "ahs":         return 32'(ia.o_hsync);
      "avs":         return 32'(ia.o_vsync);
      "aact":        return 32'(ia.o_active);
      "apix":        return 32'(ia.o_pix_en);
      "a_nfall":     return a_nfall;
      "a_hfall_x":   return a_hfall_x;
      "a_hlow":      return a_hlow;
      "a_hper":      return a_hper;
      "a_act_delay": return a_act_delay;
      "bx":          return 32'(ib.o_x);
      "by":          return 32'(ib.o_y);
      "bhs":         return 32'(ib.o_hsync);
      "bvs":         return 32'(ib.o_vsync);
      "bact":        return 32'(ib.o_active);
      "bpix":        return 32'(ib.o_pix_en);
      "b_nfe":       return b_nfe;
      "b_fper":      return b_fper;
      "b_fe_ok":     return b_fe_ok;
      "b_wrap_xy":   return 32'(b_wrap_xy);
      "b_vlow":      return b_vlow;
      "b_vfall_y":   return b_vfall_y;
      "b_hlow":      return b_hlow;
      "b_hper":      return b_hper;
      "b_hfall_x":   return b_hfall_x;
      default:       return 'x;
    endcase
  endfunction

  task automatic expect_v(input string n, input int e);
    sb.push_back('{name: n, exp: e});
  endtask

  // monitor: measure sync/frame events on the falling edge, then drain the scoreboard
  initial forever begin
    @(negedge clk);
    cyc++;
    if (a_hs_p === 1'b1 && ia.o_hsync === 1'b0) begin
      a_nfall++;
      a_hper = cyc - a_hfall;
      a_hfall = cyc;
      a_hfall_x = int'(ia.o_x);
    end
    if (a_hs_p === 1'b0 && ia.o_hsync === 1'b1) begin
      a_hlow = cyc - a_hfall;
      a_hrise = cyc;
    end
    if (a_act_p === 1'b0 && ia.o_active === 1'b1) a_act_delay = cyc - a_hrise;
    a_hs_p = ia.o_hsync;
    a_act_p = ia.o_active;
    if (b_hs_p === 1'b1 && ib.o_hsync === 1'b0) begin
      b_hper = cyc - b_hfall;
      b_hfall = cyc;
      b_hfall_x = int'(ib.o_x);
    end
    if (b_hs_p === 1'b0 && ib.o_hsync === 1'b1) b_hlow = cyc - b_hfall;
    if (b_vs_p === 1'b1 && ib.o_vsync === 1'b0) begin
      b_vfall = cyc;
      b_vfall_y = int'(ib.o_y);
    end
    if (b_vs_p === 1'b0 && ib.o_vsync === 1'b1) b_vlow = cyc - b_vfall;
    if (b_fe_p) b_wrap_xy = {ib.o_x, ib.o_y};
    if (ib.o_frame_end === 1'b1) begin
      b_nfe++;
      b_fper = cyc - b_fe_t;
      b_fe_t = cyc;
      b_fe_ok = (ib.o_line_end === 1'b1 && ib.o_x == 10'd13 && ib.o_y == 10'd7) ? 1 : 0;
    end
    b_hs_p = ib.o_hsync;
    b_vs_p = ib.o_vsync;
    b_fe_p = (ib.o_frame_end === 1'b1);
    while (sb.size() > 0) begin
      chk_t c;
      logic [31:0] a;
      c = sb.pop_front();
      a = actual(c.name);
      n_vec++;
      if (a !== 32'(c.exp)) begin
        n_bad++;
        $display("FAIL %s: got %0d, expected %0d", c.name, a, c.exp);
      end
    end
  end

  initial begin
    ia.i_en = 1'b1;
    ib.i_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
    expect_v("ax", 0); expect_v("ay", 0); expect_v("ahs", 1); expect_v("avs", 1);
    expect_v("aact", 1); expect_v("apix", 0);
    @(posedge clk); #1;
    expect_v("apix", 1); expect_v("ax", 0);
    @(posedge clk); #1;
    expect_v("ax", 1); expect_v("apix", 0);
    for (int i = 0; i < 4000 && a_nfall < 2; i++) @(posedge clk);
    #1;
    expect_v("a_nfall", 2); expect_v("a_hfall_x", 656); expect_v("a_hlow", 192);
    expect_v("a_hper", 1600); expect_v("a_act_delay", 96);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (ia.o_x == 10'd300) break;
    end
    expect_v("ax", 300);
    ia.i_en = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      expect_v("ax", 300); expect_v("apix", 0);
    end
    expect_v("ay", 2); expect_v("ahs", 1); expect_v("avs", 1); expect_v("aact", 1);
    ia.i_en = 1'b1;
    expect_v("ax", 300); expect_v("apix", 0);
    @(posedge clk); #1;
    expect_v("ax", 300); expect_v("apix", 1);
    @(posedge clk); #1;
    expect_v("ax", 301); expect_v("apix", 0);

    @(posedge clk); #1;
    rst_b = 1'b0;
    expect_v("bx", 0); expect_v("by", 0); expect_v("bpix", 1); expect_v("bhs", 1);
    @(posedge clk); #1;
    expect_v("bx", 1);
    for (int i = 0; i < 400 && b_nfe < 2; i++) @(posedge clk);
    #1;
    expect_v("b_nfe", 2); expect_v("b_fper", 112); expect_v("b_fe_ok", 1);
    expect_v("b_wrap_xy", 0); expect_v("b_vlow", 28); expect_v("b_vfall_y", 5);
    expect_v("b_hlow", 3); expect_v("b_hper", 14); expect_v("b_hfall_x", 10);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ib.o_y == 10'd5 && ib.o_x == 10'd11) break;
    end
    expect_v("bvs", 0); expect_v("bhs", 0);
    rst_b = 1'b1;
    @(posedge clk); #1;
    expect_v("bx", 0); expect_v("by", 0); expect_v("bvs", 1); expect_v("bhs", 1); expect_v("bact", 1);
    rst_b = 1'b0;
    @(posedge clk); #1;
    expect_v("bx", 1);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
